// File: rtl/ranger.sv
// Purpose : shared register map, CTRL/STAT bit positions and CTRL struct for gp_timer.
// Latency : n/a (constants, types and a pure packing function only).
// Backpressure: n/a.
//
// Contents:
//   ADDR_*        word offsets decoded from bus_addr
//   CTRL_*_BIT    CTRL bit positions, CTRL_PRESCALE_LSB/W for the prescale field
//   STAT_*_BIT    STAT bit positions (write-1-to-clear flags)
//   timer_ctrl_t  packed view of the implemented CTRL bits
//   ctrl_pack()   expands timer_ctrl_t into the 32-bit CTRL read image
package ranger;

    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_CNT  = 3'd1;
    localparam logic [2:0] ADDR_CMP  = 3'd2;
    localparam logic [2:0] ADDR_STAT = 3'd3;
    localparam logic [2:0] ADDR_CAP  = 3'd4;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_ONESHOT_BIT  = 1;
    localparam int CTRL_IE_BIT       = 2;
    localparam int CTRL_CAPIE_BIT    = 3;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_W   = 8;

    localparam int STAT_OVF_BIT  = 0;
    localparam int STAT_CAPF_BIT = 1;

    typedef struct packed {
        logic [CTRL_PRESCALE_W-1:0] prescale;
        logic                       capie;
        logic                       ie;
        logic                       oneshot;
        logic                       en;
    } timer_ctrl_t;

    // Unimplemented CTRL bits read back as zero.
    function automatic logic [31:0] ctrl_pack(input timer_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]      = c.en;
        w[CTRL_ONESHOT_BIT] = c.oneshot;
        w[CTRL_IE_BIT]      = c.ie;
        w[CTRL_CAPIE_BIT]   = c.capie;
        w[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W] = c.prescale;
        return w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Purpose : two-flop synchronizer for a single asynchronous level, both flops reset to 0.
// Latency : 2 clk cycles from d to q.
// Backpressure: none (free-running sampler).
//
// Ports: clk, rst_n (synchronous, active-low), d (async input), q (synchronized output).
// Only needed by capture builds (GP_TIMER_CAPTURE_EN); the module body is compiled
// only under that macro so non-capture builds carry no orphan top-level module.
`ifdef GP_TIMER_CAPTURE_EN
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`endif

// File: rtl/gp_timer.sv
// Purpose : general-purpose prescaled 32-bit timer with compare/reload, overflow IRQ and optional capture.
// Latency : register writes take effect on the next edge; timer_int is a one-cycle pulse the cycle after the event.
// Backpressure: none; the bus accepts every read/write strobe, reads are combinational.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus_rd_en/wr_en     register read/write strobes
//   bus_addr[2:0]       word offset: 0 CTRL, 1 CNT, 2 CMP, 3 STAT, 4 CAP (5-7 read 0)
//   bus_wr_data[31:0]   write data; bus_rd_data[31:0] combinational read data
//   timer_int           single-cycle interrupt pulse to the trap unit's pending-bit set input
//   capture_in          async capture pin, present only when GP_TIMER_CAPTURE_EN is defined
// Build option: GP_TIMER_CAPTURE_EN adds capture_in, its synchronizer, CAP, CAPF and CAPIE.
module gp_timer
    import ranger::*;
#(
    parameter logic [31:0] RESET_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_rd_en,
    input  logic        bus_wr_en,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wr_data,
    output logic [31:0] bus_rd_data,
    output logic        timer_int
`ifdef GP_TIMER_CAPTURE_EN
    ,
    input  logic        capture_in
`endif
);

    timer_ctrl_t r_ctrl;
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic [CTRL_PRESCALE_W-1:0] r_presc;
    logic        r_ovf;
    logic        r_capf;
    logic        r_int;

    timer_ctrl_t w_ctrl_wdat;
    logic        w_wr_ctrl;
    logic        w_wr_cnt;
    logic        w_wr_cmp;
    logic        w_wr_stat;
    logic        w_tick;
    logic        w_match;
    logic        w_ovf_evt;
    logic        w_cap_evt;
    logic [31:0] w_cap_val;
    logic [31:0] w_stat;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign w_wr_ctrl = bus_wr_en && (bus_addr == ADDR_CTRL);
    assign w_wr_cnt  = bus_wr_en && (bus_addr == ADDR_CNT);
    assign w_wr_cmp  = bus_wr_en && (bus_addr == ADDR_CMP);
    assign w_wr_stat = bus_wr_en && (bus_addr == ADDR_STAT);

    always_comb begin
        w_ctrl_wdat          = '0;
        w_ctrl_wdat.en       = bus_wr_data[CTRL_EN_BIT];
        w_ctrl_wdat.oneshot  = bus_wr_data[CTRL_ONESHOT_BIT];
        w_ctrl_wdat.ie       = bus_wr_data[CTRL_IE_BIT];
`ifdef GP_TIMER_CAPTURE_EN
        w_ctrl_wdat.capie    = bus_wr_data[CTRL_CAPIE_BIT];
`else
        // No capture hardware: CAPIE is hard-wired to 0 and ignores writes.
        w_ctrl_wdat.capie    = 1'b0;
`endif
        w_ctrl_wdat.prescale = bus_wr_data[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
    end

    // ------------------------------------------------------------------
    // Tick / overflow qualification
    // ------------------------------------------------------------------
    assign w_tick  = r_ctrl.en && (r_presc == r_ctrl.prescale);
    assign w_match = (r_cnt == r_cmp);
    // A software CNT write in a tick cycle owns the counter, so it also
    // suppresses the overflow that the old value would have produced.
    assign w_ovf_evt = w_tick && w_match && !w_wr_cnt;

    // ------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------
`ifdef GP_TIMER_CAPTURE_EN
    logic        w_cap_sync;
    logic        r_cap_sync_d;
    logic [31:0] r_cap;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (capture_in),
        .q     (w_cap_sync)
    );

    // Rising edge of the synchronized pin; CAP samples CNT as it stands in
    // that cycle (i.e. two cycles after the pin was first seen high).
    assign w_cap_evt = w_cap_sync && !r_cap_sync_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_sync_d <= 1'b0;
            r_cap        <= '0;
        end else begin
            r_cap_sync_d <= w_cap_sync;
            if (w_cap_evt) begin
                r_cap <= r_cnt;
            end
        end
    end

    assign w_cap_val = r_cap;
`else
    assign w_cap_evt = 1'b0;
    assign w_cap_val = '0;
`endif

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl  <= '0;
            r_cnt   <= '0;
            r_cmp   <= RESET_CMP;
            r_presc <= '0;
            r_ovf   <= 1'b0;
            r_capf  <= 1'b0;
            r_int   <= 1'b0;
        end else begin
            // A CTRL write always wins, so rewriting ONESHOT=1 in the
            // overflow cycle leaves EN at whatever software wrote.
            if (w_wr_ctrl) begin
                r_ctrl <= w_ctrl_wdat;
            end else if (w_ovf_evt && r_ctrl.oneshot) begin
                r_ctrl.en <= 1'b0;
            end

            // Prescaler idles at 0 while disabled, so enabling always starts
            // a fresh prescale period; a disabling write clears it at once.
            if (!r_ctrl.en || (w_wr_ctrl && !w_ctrl_wdat.en) || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_wr_cnt) begin
                r_cnt <= bus_wr_data;
            end else if (w_tick) begin
                r_cnt <= w_match ? 32'd0 : r_cnt + 32'd1;
            end

            if (w_wr_cmp) begin
                r_cmp <= bus_wr_data;
            end

            // W1C with set priority: a new event in the clearing cycle survives.
            r_ovf  <= (r_ovf  && !(w_wr_stat && bus_wr_data[STAT_OVF_BIT]))  || w_ovf_evt;
            r_capf <= (r_capf && !(w_wr_stat && bus_wr_data[STAT_CAPF_BIT])) || w_cap_evt;

            // Both sources merge into one pulse when they coincide.
            r_int <= (w_ovf_evt && r_ctrl.ie) || (w_cap_evt && r_ctrl.capie);
        end
    end

    assign timer_int = r_int;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_stat                = '0;
        w_stat[STAT_OVF_BIT]  = r_ovf;
        w_stat[STAT_CAPF_BIT] = r_capf;
    end

    always_comb begin
        bus_rd_data = '0;
        if (bus_rd_en) begin
            case (bus_addr)
                ADDR_CTRL: bus_rd_data = ctrl_pack(r_ctrl);
                ADDR_CNT:  bus_rd_data = r_cnt;
                ADDR_CMP:  bus_rd_data = r_cmp;
                ADDR_STAT: bus_rd_data = w_stat;
                ADDR_CAP:  bus_rd_data = w_cap_val;
                default:   bus_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gp_timer.sv
// Purpose : directed self-checking bench for gp_timer (default and GP_TIMER_CAPTURE_EN builds).
// Latency : inputs driven at the falling edge, DUT captures on the rising edge.
// Backpressure: n/a.
module tb_gp_timer;
    import ranger::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_rd_en;
    logic        bus_wr_en;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        timer_int;
`ifdef GP_TIMER_CAPTURE_EN
    logic        capture_in;
    localparam logic [31:0] EXP_CTRL_MASK = 32'h0000_FF08;
`else
    localparam logic [31:0] EXP_CTRL_MASK = 32'h0000_FF00;
`endif

    int checks   = 0;
    int failures = 0;

    gp_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_rd_en   (bus_rd_en),
        .bus_wr_en   (bus_wr_en),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .timer_int   (timer_int)
`ifdef GP_TIMER_CAPTURE_EN
        ,
        .capture_in  (capture_in)
`endif
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle write: applied at the falling edge, taken on the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_wr_en   = 1'b1;
        bus_addr    = a;
        bus_wr_data = d;
        @(negedge clk);
        bus_wr_en   = 1'b0;
        bus_wr_data = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus_rd_en = 1'b1;
        bus_addr  = a;
        #1;
        check32(tag, bus_rd_data, exp);
        bus_rd_en = 1'b0;
    endtask

    task automatic chk_int(input logic exp, input string tag);
        check32(tag, {31'd0, timer_int}, {31'd0, exp});
    endtask

    initial begin
        rst_n       = 1'b0;
        bus_rd_en   = 1'b0;
        bus_wr_en   = 1'b0;
        bus_addr    = '0;
        bus_wr_data = '0;
`ifdef GP_TIMER_CAPTURE_EN
        capture_in  = 1'b0;
`endif
        step(3);
        rst_n = 1'b1;

        // Reset values and read decode
        chk_int(1'b0, "rst_int");
        rd(ADDR_CTRL, 32'h0, "rst_ctrl");
        rd(ADDR_CNT,  32'h0, "rst_cnt");
        rd(ADDR_CMP,  32'hFFFF_FFFF, "rst_cmp");
        step(1);
        rd(ADDR_STAT, 32'h0, "rst_stat");
        rd(ADDR_CAP,  32'h0, "rst_cap");
        rd(3'd5,      32'h0, "unmapped5");
        step(1);
        rd(3'd7,      32'h0, "unmapped7");
        bus_rd_en = 1'b0;
        bus_addr  = ADDR_CMP;
        #1;
        check32("rd_en_low", bus_rd_data, 32'h0);
        step(1);

        // Unimplemented CTRL bits read 0 (EN left clear)
        wr(ADDR_CTRL, 32'hFFFF_FFF8);
        rd(ADDR_CTRL, EXP_CTRL_MASK, "ctrl_mask");
        wr(ADDR_CTRL, 32'h0);

        // PRESCALE=0, CMP=3, IE, EN: 0,1,2,3,0 with a pulse every 4 cycles
        wr(ADDR_CMP, 32'd3);
        wr(ADDR_CTRL, 32'h5);
        rd(ADDR_CNT, 32'd0, "p0_cnt0");
        chk_int(1'b0, "p0_int_a");
        step(1); rd(ADDR_CNT, 32'd1, "p0_cnt1");
        step(1); rd(ADDR_CNT, 32'd2, "p0_cnt2");
        step(1); rd(ADDR_CNT, 32'd3, "p0_cnt3");
        chk_int(1'b0, "p0_int_b");
        step(1); rd(ADDR_CNT, 32'd0, "p0_wrap");
        chk_int(1'b1, "p0_pulse1");
        rd(ADDR_STAT, 32'h1, "p0_ovf");
        step(1); rd(ADDR_CNT, 32'd1, "p0_cnt1b");
        chk_int(1'b0, "p0_pulse1_end");
        step(3); chk_int(1'b1, "p0_pulse2");
        rd(ADDR_CNT, 32'd0, "p0_wrap2");
        step(1); chk_int(1'b0, "p0_pulse2_end");

        // Disable freezes CNT (counter advanced once in the write cycle)
        wr(ADDR_CTRL, 32'h0);
        step(3);
        rd(ADDR_CNT, 32'd2, "freeze_cnt");

        // STAT write-1-to-clear
        wr(ADDR_STAT, 32'h0);
        rd(ADDR_STAT, 32'h1, "w0_no_clear");
        wr(ADDR_STAT, 32'h2);
        rd(ADDR_STAT, 32'h1, "w_capf_keeps_ovf");
        wr(ADDR_STAT, 32'h1);
        rd(ADDR_STAT, 32'h0, "w1c_ovf");

        // PRESCALE=2, CMP=1, ONESHOT, IE
        wr(ADDR_CNT, 32'd0);
        wr(ADDR_CMP, 32'd1);
        wr(ADDR_CTRL, 32'h207);
        rd(ADDR_CNT, 32'd0, "os_cnt_start");
        step(2); rd(ADDR_CNT, 32'd0, "os_cnt_pre");
        step(1); rd(ADDR_CNT, 32'd1, "os_cnt_tick1");
        step(2); rd(ADDR_CNT, 32'd1, "os_cnt_hold");
        chk_int(1'b0, "os_int_pre");
        step(1); rd(ADDR_CNT, 32'd0, "os_wrap");
        chk_int(1'b1, "os_pulse");
        rd(ADDR_CTRL, 32'h206, "os_en_cleared");
        rd(ADDR_STAT, 32'h1, "os_ovf");
        step(1); chk_int(1'b0, "os_pulse_end");
        step(5); rd(ADDR_CNT, 32'd0, "os_cnt_stays");
        rd(ADDR_CTRL, 32'h206, "os_ctrl_stays");
        chk_int(1'b0, "os_no_repeat");
        wr(ADDR_STAT, 32'h1);

        // CNT write in a matching tick cycle wins, no overflow
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_CMP, 32'd5);
        wr(ADDR_CNT, 32'd5);
        wr(ADDR_CTRL, 32'h5);
        wr(ADDR_CNT, 32'h10);
        rd(ADDR_CNT, 32'h10, "cntwr_wins");
        rd(ADDR_STAT, 32'h0, "cntwr_no_ovf");
        chk_int(1'b0, "cntwr_no_pulse_a");
        step(1); rd(ADDR_CNT, 32'h11, "cntwr_resume");
        chk_int(1'b0, "cntwr_no_pulse_b");
        wr(ADDR_CTRL, 32'h0);

        // CMP=0, IE=0: overflow every tick, no interrupt; W1C vs new overflow
        wr(ADDR_CMP, 32'd0);
        wr(ADDR_CNT, 32'd0);
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_STAT, 32'h0, "cmp0_pre");
        step(1); rd(ADDR_STAT, 32'h1, "cmp0_ovf");
        rd(ADDR_CNT, 32'd0, "cmp0_cnt");
        chk_int(1'b0, "ie0_no_int");
        wr(ADDR_STAT, 32'h1);
        rd(ADDR_STAT, 32'h1, "w1c_vs_new_ovf");
        chk_int(1'b0, "ie0_no_int_b");
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_STAT, 32'h1);
        rd(ADDR_STAT, 32'h0, "w1c_alone");

        // CTRL write with ONESHOT in an overflow cycle keeps written EN
        wr(ADDR_CTRL, 32'h3);
        wr(ADDR_CTRL, 32'h3);
        rd(ADDR_CTRL, 32'h3, "ctrlwr_wins");
        step(1); rd(ADDR_CTRL, 32'h2, "oneshot_clears");
        rd(ADDR_STAT, 32'h1, "oneshot_ovf");
        wr(ADDR_STAT, 32'h1);

        // Reset mid-count aborts the pending pulse
        wr(ADDR_CMP, 32'd2);
        wr(ADDR_CNT, 32'd0);
        wr(ADDR_CTRL, 32'h5);
        step(2); rd(ADDR_CNT, 32'd2, "pre_rst_cnt");
        rst_n = 1'b0;
        step(1);
        chk_int(1'b0, "rst_abort_int");
        rd(ADDR_CNT, 32'd0, "rst2_cnt");
        rd(ADDR_CMP, 32'hFFFF_FFFF, "rst2_cmp");
        rd(ADDR_CTRL, 32'h0, "rst2_ctrl");
        step(1);
        rd(ADDR_STAT, 32'h0, "rst2_stat");
        rst_n = 1'b1;
        step(1);

`ifdef GP_TIMER_CAPTURE_EN
        // Capture: pin rises at CNT=5, synchronizer delays two cycles -> CAP=7
        wr(ADDR_CTRL, 32'h9);
        step(5); rd(ADDR_CNT, 32'd5, "cap_cnt5");
        capture_in = 1'b1;
        step(1); chk_int(1'b0, "cap_int_a");
        step(1); chk_int(1'b0, "cap_int_b");
        step(1); chk_int(1'b1, "cap_pulse");
        rd(ADDR_CAP, 32'd7, "cap_val");
        rd(ADDR_STAT, 32'h2, "cap_flag");
        step(1); chk_int(1'b0, "cap_pulse_end");
        capture_in = 1'b0;
        wr(ADDR_STAT, 32'h2);
        rd(ADDR_STAT, 32'h0, "capf_w1c");
`else
        // No capture hardware: CAPIE and CAPF ignore writes, CAP reads 0
        wr(ADDR_CTRL, 32'h8);
        rd(ADDR_CTRL, 32'h0, "capie_ignored");
        rd(ADDR_CAP, 32'h0, "cap_absent");
        wr(ADDR_STAT, 32'h2);
        rd(ADDR_STAT, 32'h0, "capf_absent");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
